// File: rtl/arm_mem_stage_if.sv
// Bundle of EX/MEM inputs, data-memory handshake and MEM/WB outputs of arm_mem_stage.
// master = the memory stage itself, slave = its surroundings (pipeline + data memory).
interface arm_mem_stage_if;
    logic        EXMEM_valid;
    logic [31:0] EXMEM_alu_result;
    logic [31:0] EXMEM_store_data;
    logic        EXMEM_mem_read;
    logic        EXMEM_mem_write;
    logic        EXMEM_byte;
    logic        EXMEM_rd_we;
    logic        EXMEM_rd_data_sel;
    logic [3:0]  EXMEM_des_reg_num;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    logic        mem_stall;
    logic        mem_timeout;

    logic [31:0] MEMWB_data_read_from_mem;
    logic [31:0] MEMWB_rd_data;
    logic        MEMWB_rd_we;
    logic        MEMWB_rd_data_sel;
    logic [3:0]  MEMWB_des_reg_num;

    modport master (
        input  EXMEM_valid, EXMEM_alu_result, EXMEM_store_data, EXMEM_mem_read,
               EXMEM_mem_write, EXMEM_byte, EXMEM_rd_we, EXMEM_rd_data_sel,
               EXMEM_des_reg_num, dmem_rdata, dmem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
               mem_stall, mem_timeout,
               MEMWB_data_read_from_mem, MEMWB_rd_data, MEMWB_rd_we,
               MEMWB_rd_data_sel, MEMWB_des_reg_num
    );

    modport slave (
        output EXMEM_valid, EXMEM_alu_result, EXMEM_store_data, EXMEM_mem_read,
               EXMEM_mem_write, EXMEM_byte, EXMEM_rd_we, EXMEM_rd_data_sel,
               EXMEM_des_reg_num, dmem_rdata, dmem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
               mem_stall, mem_timeout,
               MEMWB_data_read_from_mem, MEMWB_rd_data, MEMWB_rd_we,
               MEMWB_rd_data_sel, MEMWB_des_reg_num
    );
endinterface

// File: rtl/arm_mem_stage.sv
// ARM memory-access stage + MEM/WB register: req/ack data-memory access with stall and MAX_WAIT abort.
// Define ARM_MEM_UNALIGNED_ROTATE_EN to rotate unaligned word loads (ARM LDR semantics).
module arm_mem_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    arm_mem_stage_if.master    bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           timeout_q;

    logic           acc;
    logic           cnt_max;
    logic           req;
    logic           stall;
    logic           abort;
    logic [1:0]     lane;
    logic [31:0]    rot;
    logic [31:0]    load_dat;

    assign acc     = bus.EXMEM_valid & (bus.EXMEM_mem_read | bus.EXMEM_mem_write);
    assign cnt_max = (cnt_q == CW'(MAX_WAIT));
    assign lane    = bus.EXMEM_alu_result[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (acc && !bus.dmem_ack) begin
                    state_d = WAIT_ACK;
                    cnt_d   = CW'(1);
                end
            end
            WAIT_ACK: begin
                if (bus.dmem_ack || cnt_max) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset gates req/stall combinationally so an in-flight access is dropped at once.
    always_comb begin
        req   = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
        case (state_q)
            IDLE: begin
                req   = acc;
                stall = acc & ~bus.dmem_ack;
            end
            WAIT_ACK: begin
                req   = 1'b1;
                stall = ~bus.dmem_ack & ~cnt_max;
                abort = ~bus.dmem_ack & cnt_max;
            end
            default: ;
        endcase
        if (rst) begin
            req   = 1'b0;
            stall = 1'b0;
            abort = 1'b0;
        end
    end

    assign bus.dmem_req    = req;
    assign bus.dmem_we     = req & bus.EXMEM_mem_write;
    assign bus.dmem_addr   = {bus.EXMEM_alu_result[31:2], 2'b00};
    assign bus.dmem_wdata  = bus.EXMEM_byte ? {4{bus.EXMEM_store_data[7:0]}} : bus.EXMEM_store_data;
    assign bus.dmem_be     = bus.EXMEM_byte ? (4'b0001 << lane) : 4'hF;
    assign bus.mem_stall   = stall;
    assign bus.mem_timeout = timeout_q;

    // Rotating right by the byte offset puts the addressed lane in bits 7:0.
    always_comb begin
        case (lane)
            2'd1:    rot = {bus.dmem_rdata[7:0],  bus.dmem_rdata[31:8]};
            2'd2:    rot = {bus.dmem_rdata[15:0], bus.dmem_rdata[31:16]};
            2'd3:    rot = {bus.dmem_rdata[23:0], bus.dmem_rdata[31:24]};
            default: rot = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        if (bus.EXMEM_byte) begin
            load_dat = {24'h0, rot[7:0]};
        end else begin
`ifdef ARM_MEM_UNALIGNED_ROTATE_EN
            load_dat = rot;
`else
            load_dat = bus.dmem_rdata;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (abort) begin
            timeout_q <= 1'b1;
        end
    end

    // A stalled cycle inserts a bubble; an aborted access retires without writing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.MEMWB_data_read_from_mem <= '0;
            bus.MEMWB_rd_data            <= '0;
            bus.MEMWB_rd_we              <= 1'b0;
            bus.MEMWB_rd_data_sel        <= 1'b0;
            bus.MEMWB_des_reg_num        <= '0;
        end else if (stall) begin
            bus.MEMWB_rd_we              <= 1'b0;
        end else begin
            bus.MEMWB_data_read_from_mem <= load_dat;
            bus.MEMWB_rd_data            <= bus.EXMEM_alu_result;
            bus.MEMWB_rd_we              <= bus.EXMEM_valid & bus.EXMEM_rd_we & ~abort;
            bus.MEMWB_rd_data_sel        <= bus.EXMEM_rd_data_sel;
            bus.MEMWB_des_reg_num        <= bus.EXMEM_des_reg_num;
        end
    end
endmodule

// File: tb/tb_arm_mem_stage.sv
// Directed bench for arm_mem_stage; expected write-backs are queued at issue and popped by a monitor.
module tb_arm_mem_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arm_mem_stage_if bus();
    arm_mem_stage dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef ARM_MEM_UNALIGNED_ROTATE_EN
    localparam logic [31:0] EXP_ROT = 32'h44112233;
`else
    localparam logic [31:0] EXP_ROT = 32'h11223344;
`endif

    typedef struct {
        logic [31:0] rd_data;
        logic        sel;
        logic [3:0]  des;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   vecs  = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        vecs++;
        if (act !== req_v) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req_v);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (!rst && bus.MEMWB_rd_we === 1'b1) begin
            vecs++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: rd_we=1 des=%0d rd_data=0x%08h, required no write",
                         bus.MEMWB_des_reg_num, bus.MEMWB_rd_data);
            end else begin
                e = q.pop_front();
                if (bus.MEMWB_rd_data !== e.rd_data || bus.MEMWB_rd_data_sel !== e.sel ||
                    bus.MEMWB_des_reg_num !== e.des ||
                    (!e.sel && bus.MEMWB_data_read_from_mem !== e.data)) begin
                    fails++;
                    $display("FAIL wb_entry: got rd_data=0x%08h sel=%0b des=%0d data=0x%08h, required rd_data=0x%08h sel=%0b des=%0d data=0x%08h",
                             bus.MEMWB_rd_data, bus.MEMWB_rd_data_sel, bus.MEMWB_des_reg_num,
                             bus.MEMWB_data_read_from_mem, e.rd_data, e.sel, e.des, e.data);
                end
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        bus.EXMEM_valid     = 1'b0;
        bus.EXMEM_mem_read  = 1'b0;
        bus.EXMEM_mem_write = 1'b0;
        bus.dmem_ack        = 1'b0;
    endtask

    // ack_at: cycle index (0 = same cycle) at which memory acks; -1 = never.
    task automatic access(input logic rd, wr, byt, we, sel, input logic [3:0] des,
                          input logic [31:0] alu, sd, rdata, input int ack_at, exp_stall,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata, exp_data);
        int  stalls;
        bit  done;
        exp_t x;
        @(posedge clk); #1;
        bus.EXMEM_valid       = 1'b1;
        bus.EXMEM_alu_result  = alu;
        bus.EXMEM_store_data  = sd;
        bus.EXMEM_mem_read    = rd;
        bus.EXMEM_mem_write   = wr;
        bus.EXMEM_byte        = byt;
        bus.EXMEM_rd_we       = we;
        bus.EXMEM_rd_data_sel = sel;
        bus.EXMEM_des_reg_num = des;
        bus.dmem_rdata        = rdata;
        if (we && !(ack_at < 0 && (rd || wr))) begin
            x.rd_data = alu; x.sel = sel; x.des = des; x.data = exp_data;
            q.push_back(x);
        end
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            bus.dmem_ack = (c == ack_at) && (rd || wr);
            #3;
            if (c == 0) begin
                chk("dmem_req", 32'(bus.dmem_req), 32'(rd | wr));
                if (rd || wr) begin
                    chk("dmem_addr",  bus.dmem_addr, {alu[31:2], 2'b00});
                    chk("dmem_we",    32'(bus.dmem_we), 32'(wr));
                    chk("dmem_be",    32'(bus.dmem_be), 32'(exp_be));
                    chk("dmem_wdata", bus.dmem_wdata, exp_wdata);
                end
            end
            if (bus.mem_stall) stalls++;
            else done = 1'b1;
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    endtask

    initial begin
        rst = 1'b1;
        bus.EXMEM_valid = 1'b0;       bus.EXMEM_alu_result = '0; bus.EXMEM_store_data = '0;
        bus.EXMEM_mem_read = 1'b0;    bus.EXMEM_mem_write = 1'b0; bus.EXMEM_byte = 1'b0;
        bus.EXMEM_rd_we = 1'b0;       bus.EXMEM_rd_data_sel = 1'b0; bus.EXMEM_des_reg_num = '0;
        bus.dmem_rdata = '0;          bus.dmem_ack = 1'b0;
        #12;
        chk("rst_req",     32'(bus.dmem_req), 0);
        chk("rst_stall",   32'(bus.mem_stall), 0);
        chk("rst_timeout", 32'(bus.mem_timeout), 0);
        chk("rst_rd_we",   32'(bus.MEMWB_rd_we), 0);
        chk("rst_rd_data", bus.MEMWB_rd_data, 0);
        chk("rst_data",    bus.MEMWB_data_read_from_mem, 0);
        @(posedge clk); #1; rst = 1'b0;

        //     rd wr by we sel des  alu           sd            rdata         ack stl be       wdata         data
        access(1, 0, 0, 1, 0, 4'd1, 32'h100,      32'h0,        32'hDEADBEEF, 0, 0, 4'hF,    32'h0,        32'hDEADBEEF);
        access(0, 0, 0, 1, 1, 4'd3, 32'h12345678, 32'h0,        32'h0,       -1, 0, 4'hF,    32'h0,        32'h0);
        access(1, 0, 1, 1, 0, 4'd2, 32'h102,      32'h0,        32'h11223344, 3, 3, 4'b0100, 32'h0,        32'h00000022);
        access(0, 1, 1, 0, 0, 4'd0, 32'h203,      32'hAB,       32'h0,        0, 0, 4'b1000, 32'hABABABAB, 32'h0);
        access(0, 1, 0, 0, 0, 4'd0, 32'h304,      32'hCAFEF00D, 32'h0,        1, 1, 4'hF,    32'hCAFEF00D, 32'h0);
        access(1, 0, 1, 1, 0, 4'd7, 32'h101,      32'h0,        32'h11223344, 0, 0, 4'b0010, 32'h0,        32'h00000033);
        access(1, 0, 1, 1, 0, 4'd8, 32'h103,      32'h0,        32'h11223344, 2, 2, 4'b1000, 32'h0,        32'h00000011);
        access(1, 0, 0, 1, 0, 4'd9, 32'h101,      32'h0,        32'h11223344, 0, 0, 4'hF,    32'h0,        EXP_ROT);

        // Invalid slot with mem_read set must not request; a stray ack is ignored.
        @(posedge clk); #1;
        bus.EXMEM_valid = 1'b0; bus.EXMEM_mem_read = 1'b1; bus.dmem_ack = 1'b1;
        #3;
        chk("invalid_req",   32'(bus.dmem_req), 0);
        chk("invalid_stall", 32'(bus.mem_stall), 0);
        idle();

        access(1, 0, 0, 1, 0, 4'd5, 32'h500, 32'h0, 32'h0, -1, 15, 4'hF, 32'h0, 32'h0);
        idle(); #3;
        chk("timeout_set", 32'(bus.mem_timeout), 1);
        idle(); idle(); #3;
        chk("timeout_sticky", 32'(bus.mem_timeout), 1);

        // Reset while waiting for an ack.
        @(posedge clk); #1;
        bus.EXMEM_valid = 1'b1; bus.EXMEM_mem_read = 1'b1; bus.EXMEM_mem_write = 1'b0;
        bus.EXMEM_byte = 1'b0; bus.EXMEM_rd_we = 1'b1; bus.EXMEM_alu_result = 32'h600;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("midrst_req",     32'(bus.dmem_req), 0);
        chk("midrst_stall",   32'(bus.mem_stall), 0);
        chk("midrst_timeout", 32'(bus.mem_timeout), 0);
        chk("midrst_rd_we",   32'(bus.MEMWB_rd_we), 0);
        chk("midrst_rd_data", bus.MEMWB_rd_data, 0);
        chk("midrst_des",     32'(bus.MEMWB_des_reg_num), 0);
        bus.EXMEM_valid = 1'b0; bus.EXMEM_mem_read = 1'b0;
        @(posedge clk); #1; rst = 1'b0;

        access(1, 0, 0, 1, 0, 4'd6, 32'h400, 32'h0, 32'h0BADF00D, 1, 1, 4'hF, 32'h0, 32'h0BADF00D);
        idle(); idle(); idle();
        chk("sb_empty", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
